// File: rtl/mem_reader.sv
// Read-side sequencer for the single-port synchronous RAM: streams a contiguous,
// wrapping block of words out on a valid/ready port through a 2-entry buffer.
module mem_reader #(
  parameter int addr_width = 6,
  parameter int bus_width  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cs,
  output logic                  mem_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [bus_width-1:0]  mem_dout,
  output logic [bus_width-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]            state;
  logic [addr_width-1:0] addr;
  logic [addr_width-1:0] last_addr;
  logic [addr_width:0]   remaining;
  logic                  infl;
  logic [1:0]            occ;
  logic [bus_width-1:0]  buf0;
  logic [bus_width-1:0]  buf1;
  logic                  pop;
  logic                  issue;
  logic                  drain_done;
  logic [2:0]            pending;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = buf0;

  // Words that will occupy the buffer after this edge if nothing new is issued.
  assign pending = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign issue   = (state == READ) && (remaining != '0) && (pending < 3'd2);

  // Leave DRAIN on the edge that empties the buffer, so done follows the last pop directly.
  assign drain_done = !infl && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  assign mem_cs   = issue;
  assign mem_en   = 1'b0;
  assign mem_addr = issue ? addr : last_addr;
  assign busy     = (state == READ) || (state == DRAIN);
  assign done     = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      infl      <= 1'b0;
    end else begin
      infl <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr      <= base_addr;
              remaining <= length;
              state     <= READ;
            end else begin
              state <= FIN;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr + 1'b1;
            last_addr <= addr;
            remaining <= remaining - 1'b1;
            if (remaining == {{addr_width{1'b0}}, 1'b1}) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry buffer, buf0 is the head; a capture lands at the tail position.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({infl, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= mem_dout;
          else             buf1 <= mem_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= mem_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_reader.sv
// Randomized bench for mem_reader: a RAM model plus a per-command expected word
// queue, with timing, ordering, backpressure and flow-control rules checked each cycle.
module tb_mem_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic        busy;
  logic        done;
  logic        mem_cs;
  logic        mem_en;
  logic [5:0]  mem_addr;
  logic [13:0] mem_dout;
  logic [13:0] m_data;
  logic        m_valid;
  logic        m_ready;

  logic [13:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_reader #(.addr_width(6), .bus_width(14)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_cs(mem_cs), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Registered-read RAM: data for the address presented at an edge appears after it.
  always @(posedge clk) if (mem_cs) mem_dout <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1,1 repeating, 2 random ready.
  // inject_cyc > 0 pulses a spurious start in that cycle; abort_pops >= 0 resets after that many pops.
  task automatic run_cmd(input int base, input int len, input int mode,
                         input int inject_cyc, input int abort_pops);
    logic [13:0] expq[$];
    logic [13:0] held;
    bit   hold_chk = 0;
    bit   seen_valid = 0;
    bit   fin = 0;
    bit   pop;
    int   cyc = 1;
    int   pops = 0;
    int   issues = 0;
    int   last_pop = 0;
    int   dones = 0;
    for (int i = 0; i < len; i++) expq.push_back(mem[(base + i) % 64]);
    base_addr = base[5:0];
    length    = len[6:0];
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 600) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (((cyc - 1) % 5) != 1) && (((cyc - 1) % 5) != 2);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == inject_cyc);
      if (start) begin
        base_addr = 6'd17;
        length    = 7'd3;
      end
      #1;
      pop = m_valid && m_ready;
      check("mem_en", mem_en, 0);
      if (hold_chk) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
      end
      hold_chk = m_valid && !m_ready;
      held     = m_data;
      if (len == 0) check("zero_valid", m_valid, 0);
      else if (!seen_valid && m_valid) begin
        check("latency", cyc, 3);
        seen_valid = 1;
      end
      if (mem_cs) begin
        check("issue_room", ((issues - pops - int'(pop)) < 2), 1);
        check("issue_count", (issues < len), 1);
        check("mem_addr", mem_addr, (base + issues) % 64);
        issues++;
      end
      if (pop) begin
        if (pops < len) check("data", m_data, expq[pops]);
        else            check("pop_count", pops + 1, len);
        pops++;
        if (pops == len) last_pop = cyc;
      end
      if (abort_pops >= 0 && pops == abort_pops) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cs", mem_cs, 0);
        check("abort_done", done, 0);
        check("abort_data", m_data, 0);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check("abort_no_done", done, 0);
        end
        return;
      end
      if (done) begin
        dones++;
        check("done_time", cyc, (len == 0) ? 1 : last_pop + 1);
        check("busy_at_done", busy, 0);
      end else if (dones > 0) begin
        check("busy_after", busy, 0);
        fin = 1;
      end else begin
        check("busy_run", busy, (len > 0));
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) check("timeout", cyc, 0);
    check("pops", pops, len);
    check("issues", issues, len);
    check("dones", dones, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    for (int i = 0; i < 64; i++) mem[i] = 14'(i + 100);

    run_cmd(4, 5, 0, 0, -1);
    run_cmd(62, 4, 0, 0, -1);
    run_cmd(10, 8, 1, 0, -1);
    run_cmd(20, 0, 0, 0, -1);
    run_cmd(0, 64, 2, 5, -1);
    run_cmd(33, 6, 0, 0, -1);
    run_cmd(50, 10, 0, 0, 3);
    run_cmd(7, 10, 1, 0, -1);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 64; i++) mem[i] = 14'($urandom);
      run_cmd($urandom_range(0, 63), $urandom_range(0, 64), 2, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
